// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: writeback-stage <-> CP0 bundle
//   c0_exception[5:0] {sys,mfc0,mtc0,eret,break,ovf} of the WB instruction
//   c0_addr, c0_wdata  CP0 register number and mtc0 data
//   c0_wb_valid/bd/pc  WB instruction valid, delay-slot flag, PC
//   ext_int_in[5:0]    level-sensitive hardware interrupt lines
//   c0_valid, c0_res   mfc0 result and its valid
//   c0_int             interrupt taken on the WB instruction
//   flush, flush_pc    pipeline flush and redirect target
interface cp0_ctrl_if;
    logic [5:0]  c0_exception;
    logic [4:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic        c0_wb_valid;
    logic        c0_wb_bd;
    logic [31:0] c0_wb_pc;
    logic [5:0]  ext_int_in;
    logic        c0_valid;
    logic [31:0] c0_res;
    logic        c0_int;
    logic        flush;
    logic [31:0] flush_pc;
    modport master (
        output c0_exception, c0_addr, c0_wdata, c0_wb_valid, c0_wb_bd, c0_wb_pc, ext_int_in,
        input  c0_valid, c0_res, c0_int, flush, flush_pc
    );
    modport slave (
        input  c0_exception, c0_addr, c0_wdata, c0_wb_valid, c0_wb_bd, c0_wb_pc, ext_int_in,
        output c0_valid, c0_res, c0_int, flush, flush_pc
    );
endinterface

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 register file (Count/Compare/Status/Cause/EPC) with exception/ERET sequencer
//   clk, reset  clock and synchronous active-high reset
//   cp0         slave side of cp0_ctrl_if (WB instruction in, mfc0 result / flush / redirect out)
module cp0_ctrl #(
    parameter logic [31:0] EX_ENTRY  = 32'hBFC00380,
    parameter int          COUNT_DIV = 2
) (
    input logic      clk,
    input logic      reset,
    cp0_ctrl_if.slave cp0
);
    logic [31:0] r_count, r_compare, r_epc, r_div;
    logic [7:0]  r_im;
    logic        r_exl, r_ie, r_bd, r_ti;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exc;
    logic        w_sys, w_mfc0_op, w_mtc0_op, w_eret_op, w_brk, w_ovf;
    logic [7:0]  w_ip;
    logic [31:0] w_status, w_cause, w_rdata, w_count_nxt;
    logic        w_int, w_exc, w_eret, w_mtc0, w_mfc0, w_div_wrap, w_wr_cmp, w_wr_cnt;
    logic [4:0]  w_code;
    assign {w_sys, w_mfc0_op, w_mtc0_op, w_eret_op, w_brk, w_ovf} = cp0.c0_exception;
    // Timer match shares IP[7] with the top hardware line
    assign w_ip     = {r_ip_hw[5] | r_ti, r_ip_hw[4:0], r_ip_sw};
    assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exc, 2'b0};
    // Event decode in priority order; lower-priority events are masked by higher ones
    assign w_int  = cp0.c0_wb_valid & r_ie & ~r_exl & |(w_ip & r_im);
    assign w_exc  = cp0.c0_wb_valid & (w_int | w_ovf | w_sys | w_brk);
    assign w_code = w_int ? 5'h00 : w_ovf ? 5'h0C : w_sys ? 5'h08 : 5'h09;
    assign w_eret = cp0.c0_wb_valid & ~w_exc & w_eret_op;
    assign w_mtc0 = cp0.c0_wb_valid & ~w_exc & ~w_eret_op & w_mtc0_op;
    assign w_mfc0 = cp0.c0_wb_valid & ~w_exc & ~w_eret_op & ~w_mtc0_op & w_mfc0_op;
    assign w_rdata = (cp0.c0_addr == 5'd9)  ? r_count   :
                     (cp0.c0_addr == 5'd11) ? r_compare :
                     (cp0.c0_addr == 5'd12) ? w_status  :
                     (cp0.c0_addr == 5'd13) ? w_cause   :
                     (cp0.c0_addr == 5'd14) ? r_epc     : 32'h0;
    assign w_div_wrap  = r_div == 32'(COUNT_DIV - 1);
    assign w_wr_cmp    = w_mtc0 & (cp0.c0_addr == 5'd11);
    assign w_wr_cnt    = w_mtc0 & (cp0.c0_addr == 5'd9);
    assign w_count_nxt = w_wr_cnt ? cp0.c0_wdata : r_count + {31'b0, w_div_wrap};
    // Outputs are forced low during reset so a reset mid-exception drops flush immediately
    assign cp0.c0_valid = ~reset & w_mfc0;
    assign cp0.c0_res   = (~reset & w_mfc0) ? w_rdata : 32'h0;
    assign cp0.c0_int   = ~reset & w_int;
    assign cp0.flush    = ~reset & (w_exc | w_eret);
    assign cp0.flush_pc = reset ? 32'h0 : w_exc ? EX_ENTRY : w_eret ? r_epc : 32'h0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'h0;
            r_compare <= 32'h0;
            r_epc     <= 32'h0;
            r_div     <= 32'h0;
            r_im      <= 8'h0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ti      <= 1'b0;
            r_ip_hw   <= 6'h0;
            r_ip_sw   <= 2'h0;
            r_exc     <= 5'h0;
        end else begin
            r_div     <= w_div_wrap ? 32'h0 : r_div + 32'd1;
            r_count   <= w_count_nxt;
            r_compare <= w_wr_cmp ? cp0.c0_wdata : r_compare;
            r_ti      <= w_wr_cmp ? 1'b0 : (w_count_nxt == r_compare) ? 1'b1 : r_ti;
            r_ip_hw   <= cp0.ext_int_in;
            if (w_exc) begin
                // Nested exception keeps the original return address and BD
                if (!r_exl) begin
                    r_epc <= cp0.c0_wb_bd ? cp0.c0_wb_pc - 32'd4 : cp0.c0_wb_pc;
                    r_bd  <= cp0.c0_wb_bd;
                end
                r_exl <= 1'b1;
                r_exc <= w_code;
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end else if (w_mtc0) begin
                if (cp0.c0_addr == 5'd12) begin
                    r_im  <= cp0.c0_wdata[15:8];
                    r_exl <= cp0.c0_wdata[1];
                    r_ie  <= cp0.c0_wdata[0];
                end
                if (cp0.c0_addr == 5'd13) r_ip_sw <= cp0.c0_wdata[9:8];
                if (cp0.c0_addr == 5'd14) r_epc <= cp0.c0_wdata;
            end
        end
    end
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed self-checking bench for cp0_ctrl
module tb_cp0_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] v;
    logic        vld;
    cp0_ctrl_if bus ();
    cp0_ctrl #(.EX_ENTRY(32'hBFC00380), .COUNT_DIV(2)) dut (.clk(clk), .reset(reset), .cp0(bus));
    always #5 clk = ~clk;
    task automatic idle();
        bus.c0_exception = 6'b0;
        bus.c0_addr      = 5'd0;
        bus.c0_wdata     = 32'h0;
        bus.c0_wb_valid  = 1'b0;
        bus.c0_wb_bd     = 1'b0;
        bus.c0_wb_pc     = 32'h0;
    endtask
    task automatic fin();
        @(posedge clk);
        #1;
        idle();
    endtask
    task automatic ev(input logic [5:0] exc, input logic [31:0] pc, input logic bd);
        bus.c0_exception = exc;
        bus.c0_wb_valid  = 1'b1;
        bus.c0_wb_pc     = pc;
        bus.c0_wb_bd     = bd;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ev(6'b001000, 32'hBFC00000, 1'b0);
        bus.c0_addr  = a;
        bus.c0_wdata = d;
        fin();
    endtask
    task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic ok);
        ev(6'b010000, 32'hBFC00000, 1'b0);
        bus.c0_addr = a;
        @(negedge clk);
        d  = bus.c0_res;
        ok = bus.c0_valid;
        fin();
    endtask
    task automatic test_reset();
        ev(6'b100000, 32'hBFC00100, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", bus.flush); end
        n_cmp++; if (bus.flush_pc !== 32'h0) begin n_bad++; $display("FAIL reset_flush_pc got %h want 0", bus.flush_pc); end
        n_cmp++; if (bus.c0_int !== 1'b0) begin n_bad++; $display("FAIL reset_int got %b want 0", bus.c0_int); end
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;
        rd(5'd13, v, vld);
        n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL mfc0_valid got %b want 1", vld); end
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_cause got %h want 0", v); end
        rd(5'd12, v, vld);
        n_cmp++; if (v !== 32'h00400000) begin n_bad++; $display("FAIL reset_status got %h want 00400000", v); end
        rd(5'd14, v, vld);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h want 0", v); end
    endtask
    task automatic test_syscall();
        ev(6'b100000, 32'hBFC00100, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL sys_flush got %b want 1", bus.flush); end
        n_cmp++; if (bus.flush_pc !== 32'hBFC00380) begin n_bad++; $display("FAIL sys_flush_pc got %h want bfc00380", bus.flush_pc); end
        n_cmp++; if (bus.c0_int !== 1'b0) begin n_bad++; $display("FAIL sys_int got %b want 0", bus.c0_int); end
        fin();
        rd(5'd14, v, vld);
        n_cmp++; if (v !== 32'hBFC00100) begin n_bad++; $display("FAIL sys_epc got %h want bfc00100", v); end
        rd(5'd13, v, vld);
        n_cmp++; if (v[6:2] !== 5'h08) begin n_bad++; $display("FAIL sys_code got %h want 08", v[6:2]); end
        rd(5'd12, v, vld);
        n_cmp++; if (v !== 32'h00400002) begin n_bad++; $display("FAIL sys_exl got %h want 00400002", v); end
    endtask
    task automatic test_overflow_nested();
        wr(5'd12, 32'h0);
        ev(6'b000001, 32'hBFC00204, 1'b1);
        @(negedge clk);
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL ovf_flush got %b want 1", bus.flush); end
        fin();
        rd(5'd14, v, vld);
        n_cmp++; if (v !== 32'hBFC00200) begin n_bad++; $display("FAIL ovf_epc got %h want bfc00200", v); end
        rd(5'd13, v, vld);
        n_cmp++; if ({v[31], v[6:2]} !== 6'b1_01100) begin n_bad++; $display("FAIL ovf_bd_code got %b want 101100", {v[31], v[6:2]}); end
        ev(6'b100000, 32'hBFC00500, 1'b0);
        fin();
        rd(5'd14, v, vld);
        n_cmp++; if (v !== 32'hBFC00200) begin n_bad++; $display("FAIL nested_epc got %h want bfc00200", v); end
        rd(5'd13, v, vld);
        n_cmp++; if ({v[31], v[6:2]} !== 6'b1_01000) begin n_bad++; $display("FAIL nested_bd_code got %b want 101000", {v[31], v[6:2]}); end
    endtask
    task automatic test_valid_gate();
        ev(6'b100000, 32'hBFC00900, 1'b0);
        bus.c0_wb_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL invalid_flush got %b want 0", bus.flush); end
        fin();
        rd(5'd14, v, vld);
        n_cmp++; if (v !== 32'hBFC00200) begin n_bad++; $display("FAIL invalid_epc got %h want bfc00200", v); end
        rd(5'd5, v, vld);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_read got %h want 0", v); end
    endtask
    task automatic test_eret();
        wr(5'd14, 32'hBFC00400);
        ev(6'b000100, 32'hBFC00800, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL eret_flush got %b want 1", bus.flush); end
        n_cmp++; if (bus.flush_pc !== 32'hBFC00400) begin n_bad++; $display("FAIL eret_pc got %h want bfc00400", bus.flush_pc); end
        fin();
        rd(5'd12, v, vld);
        n_cmp++; if (v !== 32'h00400000) begin n_bad++; $display("FAIL eret_exl got %h want 00400000", v); end
    endtask
    task automatic test_timer();
        wr(5'd12, 32'h00008000);
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        repeat (14) fin();
        rd(5'd13, v, vld);
        n_cmp++; if ({v[30], v[15]} !== 2'b11) begin n_bad++; $display("FAIL timer_ti got %b want 11", {v[30], v[15]}); end
        wr(5'd12, 32'h00408001);
        ev(6'b000000, 32'hBFC00600, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.c0_int !== 1'b1) begin n_bad++; $display("FAIL timer_int got %b want 1", bus.c0_int); end
        n_cmp++; if (bus.flush_pc !== 32'hBFC00380) begin n_bad++; $display("FAIL timer_flush_pc got %h want bfc00380", bus.flush_pc); end
        fin();
        rd(5'd13, v, vld);
        n_cmp++; if (v[6:2] !== 5'h00) begin n_bad++; $display("FAIL timer_code got %h want 00", v[6:2]); end
        rd(5'd14, v, vld);
        n_cmp++; if (v !== 32'hBFC00600) begin n_bad++; $display("FAIL timer_epc got %h want bfc00600", v); end
        wr(5'd11, 32'hFFFF0000);
        rd(5'd13, v, vld);
        n_cmp++; if (v[30] !== 1'b0) begin n_bad++; $display("FAIL timer_clear got %b want 0", v[30]); end
    endtask
    task automatic test_int_priority();
        bus.ext_int_in = 6'b000001;
        wr(5'd12, 32'h00000401);
        ev(6'b000001, 32'hBFC00700, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.c0_int !== 1'b1) begin n_bad++; $display("FAIL prio_int got %b want 1", bus.c0_int); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL prio_flush got %b want 1", bus.flush); end
        fin();
        rd(5'd13, v, vld);
        n_cmp++; if ({v[10], v[6:2]} !== 6'b1_00000) begin n_bad++; $display("FAIL prio_code got %b want 100000", {v[10], v[6:2]}); end
        bus.ext_int_in = 6'b0;
    endtask
    task automatic test_reset_mid_exception();
        ev(6'b100000, 32'hBFC00A00, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL midreset_flush got %b want 0", bus.flush); end
        fin();
        reset = 1'b0;
        rd(5'd13, v, vld);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL midreset_cause got %h want 0", v); end
        rd(5'd14, v, vld);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL midreset_epc got %h want 0", v); end
    endtask
    initial begin
        idle();
        bus.ext_int_in = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_syscall();
        test_overflow_nested();
        test_valid_gate();
        test_eret();
        test_timer();
        test_int_priority();
        test_reset_mid_exception();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
